// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game datapath blocks.
//   comp_state_e    : compositor FSM encoding (IDLE / DRAW / SCAN / DRAIN)
//   DEF_SCREEN_W/H  : default visible framebuffer size in pixels
//   DEF_COLOUR_W    : default pixel colour width
//   DEF_TRANSP_KEY  : default colour treated as "see-through" by the drawers
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } comp_state_e;

  localparam int         DEF_SCREEN_W   = 256;
  localparam int         DEF_SCREEN_H   = 176;
  localparam int         DEF_COLOUR_W   = 6;
  localparam logic [5:0] DEF_TRANSP_KEY = 6'b110011;

endpackage

// File: rtl/fb_addr_translate.sv
// -----------------------------------------------------------------------------
// fb_addr_translate
// Converts an (x, y) screen coordinate into a linear framebuffer address
// y*SCREEN_W + x and flags whether the coordinate lies on the visible screen.
// Purely combinational.
//   i_x, i_y     : pixel coordinate
//   o_addr       : linear framebuffer address (ADDR_W bits)
//   o_in_range   : 1 when x < SCREEN_W and y < SCREEN_H
// -----------------------------------------------------------------------------
module fb_addr_translate #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int ADDR_W   = 16,
  parameter int SCREEN_W = 256,
  parameter int SCREEN_H = 176
) (
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_in_range
);

  localparam logic [ADDR_W-1:0] LINE_LEN = ADDR_W'(SCREEN_W);
  localparam logic [31:0]       LIM_X    = 32'(SCREEN_W);
  localparam logic [31:0]       LIM_Y    = 32'(SCREEN_H);

  logic [31:0] w_x_ext;
  logic [31:0] w_y_ext;

  assign w_x_ext = 32'(i_x);
  assign w_y_ext = 32'(i_y);

  // 2^ADDR_W >= SCREEN_W*SCREEN_H, so ADDR_W-bit arithmetic never wraps
  // for on-screen coordinates.
  assign o_addr     = (ADDR_W'(i_y) * LINE_LEN) + ADDR_W'(i_x);
  assign o_in_range = (w_x_ext < LIM_X) && (w_y_ext < LIM_Y);

endmodule

// File: rtl/fb_compositor.sv
// -----------------------------------------------------------------------------
// fb_compositor
// Arbitrates NUM_CH draw channels onto a single-port framebuffer, sweeps the
// framebuffer for VGA scan-out with read-latency alignment, and generates a
// free-running frame tick.
//
// Ports
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_ch_en / i_ch_done       : per-channel draw enable / source finished
//   i_ch_x / i_ch_y / i_ch_colour : flattened per-channel pixel (ch i at [i*W +: W])
//   i_ch_write                : per-channel pixel valid
//   o_ch_grant                : one-hot registered grant
//   i_scan_start              : request one full-frame scan-out (sticky)
//   o_fb_addr / o_fb_colour / o_fb_wren : framebuffer port
//   i_fb_q                    : framebuffer read data, RD_LAT cycles after address
//   o_vga_x / o_vga_y / o_vga_colour / o_vga_plot : aligned scan-out pixel
//   o_scan_done               : pulse one cycle after the last o_vga_plot
//   o_frame_tick              : pulse every FRAME_TICKS cycles
//   o_state                   : current FSM state (debug)
//
// Channel handshake: a channel asks for the framebuffer by holding i_ch_en high
// with i_ch_done low. Once o_ch_grant[i] is high, every cycle with
// i_ch_write[i]=1 is one pixel transfer; the grant acts as "ready" and there is
// no back-pressure while it is held. The channel gives up the port by raising
// i_ch_done[i] or dropping i_ch_en[i]; the pixel presented in that cycle is
// discarded. A channel keeps the port until it lets go (no preemption).
// -----------------------------------------------------------------------------
module fb_compositor
  import game_pkg::*;
#(
  parameter int                  NUM_CH      = 4,
  parameter int                  SCREEN_W    = DEF_SCREEN_W,
  parameter int                  SCREEN_H    = DEF_SCREEN_H,
  parameter int                  X_W         = 9,
  parameter int                  Y_W         = 8,
  parameter int                  COLOUR_W    = DEF_COLOUR_W,
  parameter int                  ADDR_W      = 16,
  parameter bit                  TRANSP_EN   = 1'b1,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY  = COLOUR_W'(DEF_TRANSP_KEY),
  parameter int                  RD_LAT      = 1,
  parameter int                  FRAME_TICKS = 1666666
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_ch_en,
  input  logic [NUM_CH-1:0]            i_ch_done,
  input  logic [NUM_CH*X_W-1:0]        i_ch_x,
  input  logic [NUM_CH*Y_W-1:0]        i_ch_y,
  input  logic [NUM_CH*COLOUR_W-1:0]   i_ch_colour,
  input  logic [NUM_CH-1:0]            i_ch_write,
  output logic [NUM_CH-1:0]            o_ch_grant,
  input  logic                         i_scan_start,
  output logic [ADDR_W-1:0]            o_fb_addr,
  output logic [COLOUR_W-1:0]          o_fb_colour,
  output logic                         o_fb_wren,
  input  logic [COLOUR_W-1:0]          i_fb_q,
  output logic [X_W-1:0]               o_vga_x,
  output logic [Y_W-1:0]               o_vga_y,
  output logic [COLOUR_W-1:0]          o_vga_colour,
  output logic                         o_vga_plot,
  output logic                         o_scan_done,
  output logic                         o_frame_tick,
  output comp_state_e                  o_state
);

  localparam int FT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  comp_state_e         r_state;
  comp_state_e         w_next_state;

  logic [NUM_CH-1:0]   r_grant;
  logic                r_scan_pend;
  logic [X_W-1:0]      r_sx;
  logic [Y_W-1:0]      r_sy;
  logic [1:0]          r_drain_cnt;
  logic [FT_W-1:0]     r_ft_cnt;
  logic                r_frame_tick;

  logic [ADDR_W-1:0]   r_fb_addr;
  logic [COLOUR_W-1:0] r_fb_colour;
  logic                r_fb_wren;
  logic                r_scan_done;

  // Scan issue stage: aligned with r_fb_addr.
  logic                r_iss_v;
  logic [X_W-1:0]      r_iss_x;
  logic [Y_W-1:0]      r_iss_y;

  // ---------------------------------------------------------------------------
  // Request arbitration: lowest-index requester wins
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]   w_req;
  logic                w_any_req;
  logic [NUM_CH-1:0]   w_pick;

  assign w_req     = i_ch_en & ~i_ch_done;
  assign w_any_req = |w_req;

  always_comb begin
    w_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted channel mux
  // ---------------------------------------------------------------------------
  logic                w_g_en;
  logic                w_g_done;
  logic                w_g_write;
  logic [X_W-1:0]      w_g_x;
  logic [Y_W-1:0]      w_g_y;
  logic [COLOUR_W-1:0] w_g_colour;

  always_comb begin
    w_g_en     = 1'b0;
    w_g_done   = 1'b0;
    w_g_write  = 1'b0;
    w_g_x      = '0;
    w_g_y      = '0;
    w_g_colour = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant[i]) begin
        w_g_en     = i_ch_en[i];
        w_g_done   = i_ch_done[i];
        w_g_write  = i_ch_write[i];
        w_g_x      = i_ch_x[i*X_W +: X_W];
        w_g_y      = i_ch_y[i*Y_W +: Y_W];
        w_g_colour = i_ch_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  logic w_release;
  logic w_scan_req;
  logic w_scan_last;
  logic w_drain_end;

  assign w_release   = w_g_done | ~w_g_en;
  assign w_scan_req  = r_scan_pend | i_scan_start;
  assign w_scan_last = (r_sx == X_W'(SCREEN_W - 1)) && (r_sy == Y_W'(SCREEN_H - 1));
  // The extra DRAIN cycle past RD_LAT lets scan_done land one cycle after the
  // last aligned pixel rather than on it.
  assign w_drain_end = (r_drain_cnt == 2'(RD_LAT));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // Drawing beats a simultaneous scan request; the scan stays pending.
        if (w_any_req)       w_next_state = ST_DRAW;
        else if (w_scan_req) w_next_state = ST_SCAN;
      end
      ST_DRAW:  if (w_release)   w_next_state = ST_IDLE;
      ST_SCAN:  if (w_scan_last) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  logic w_take_draw;
  logic w_take_scan;
  logic w_draw_act;
  logic w_scan_act;
  logic w_drain_act;
  logic w_done_pulse;

  always_comb begin
    w_take_draw  = 1'b0;
    w_take_scan  = 1'b0;
    w_draw_act   = 1'b0;
    w_scan_act   = 1'b0;
    w_drain_act  = 1'b0;
    w_done_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_take_draw = w_any_req;
        w_take_scan = ~w_any_req & w_scan_req;
      end
      ST_DRAW:  w_draw_act = ~w_release;
      ST_SCAN:  w_scan_act = 1'b1;
      ST_DRAIN: begin
        w_drain_act  = 1'b1;
        w_done_pulse = w_drain_end;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared address translation: scan counter while scanning, else draw pixel
  // ---------------------------------------------------------------------------
  logic [X_W-1:0]    w_tr_x;
  logic [Y_W-1:0]    w_tr_y;
  logic [ADDR_W-1:0] w_tr_addr;
  logic              w_tr_in_range;

  assign w_tr_x = w_scan_act ? r_sx : w_g_x;
  assign w_tr_y = w_scan_act ? r_sy : w_g_y;

  fb_addr_translate #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .ADDR_W   (ADDR_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr (
    .i_x        (w_tr_x),
    .i_y        (w_tr_y),
    .o_addr     (w_tr_addr),
    .o_in_range (w_tr_in_range)
  );

  logic w_is_key;
  logic w_wr_ok;

  assign w_is_key = TRANSP_EN && (w_g_colour == TRANSP_KEY);
  assign w_wr_ok  = w_draw_act & w_g_write & w_tr_in_range & ~w_is_key;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant     <= '0;
      r_scan_pend <= 1'b0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_drain_cnt <= '0;
      r_fb_addr   <= '0;
      r_fb_colour <= '0;
      r_fb_wren   <= 1'b0;
      r_scan_done <= 1'b0;
      r_iss_v     <= 1'b0;
      r_iss_x     <= '0;
      r_iss_y     <= '0;
    end else begin
      if (w_take_draw)                         r_grant <= w_pick;
      else if (r_state == ST_DRAW && w_release) r_grant <= '0;

      if (w_take_scan)       r_scan_pend <= 1'b0;
      else if (i_scan_start) r_scan_pend <= 1'b1;

      if (w_take_scan) begin
        r_sx <= '0;
        r_sy <= '0;
      end else if (w_scan_act) begin
        if (r_sx == X_W'(SCREEN_W - 1)) begin
          r_sx <= '0;
          r_sy <= (r_sy == Y_W'(SCREEN_H - 1)) ? '0 : r_sy + Y_W'(1);
        end else begin
          r_sx <= r_sx + X_W'(1);
        end
      end

      r_drain_cnt <= w_drain_act ? r_drain_cnt + 2'd1 : 2'd0;

      if (w_draw_act || w_scan_act) r_fb_addr   <= w_tr_addr;
      if (w_draw_act)               r_fb_colour <= w_g_colour;
      r_fb_wren   <= w_wr_ok;
      r_scan_done <= w_done_pulse;

      r_iss_v <= w_scan_act;
      r_iss_x <= r_sx;
      r_iss_y <= r_sy;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-alignment delay line: RD_LAT stages behind the issued address
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < RD_LAT; k++) begin : g_dl
    logic           r_v;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    if (k == 0) begin : g_head
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_v <= 1'b0;
          r_x <= '0;
          r_y <= '0;
        end else begin
          r_v <= r_iss_v;
          r_x <= r_iss_x;
          r_y <= r_iss_y;
        end
      end
    end else begin : g_tail
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_v <= 1'b0;
          r_x <= '0;
          r_y <= '0;
        end else begin
          r_v <= g_dl[k-1].r_v;
          r_x <= g_dl[k-1].r_x;
          r_y <= g_dl[k-1].r_y;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame pacing counter, free-running in every state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ft_cnt     <= '0;
      r_frame_tick <= 1'b0;
    end else if (r_ft_cnt == FT_W'(FRAME_TICKS - 1)) begin
      r_ft_cnt     <= '0;
      r_frame_tick <= 1'b1;
    end else begin
      r_ft_cnt     <= r_ft_cnt + FT_W'(1);
      r_frame_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ch_grant   = r_grant;
  assign o_fb_addr    = r_fb_addr;
  assign o_fb_colour  = r_fb_colour;
  assign o_fb_wren    = r_fb_wren;
  assign o_vga_plot   = g_dl[RD_LAT-1].r_v;
  assign o_vga_x      = g_dl[RD_LAT-1].r_x;
  assign o_vga_y      = g_dl[RD_LAT-1].r_y;
  assign o_vga_colour = o_vga_plot ? i_fb_q : '0;
  assign o_scan_done  = r_scan_done;
  assign o_frame_tick = r_frame_tick;
  assign o_state      = r_state;

endmodule

// File: doc/fb_compositor.md
# fb_compositor

Parametrised framebuffer compositor and scan-out engine, successor to the game datapath's hard-wired draw multiplexer. It arbitrates N sprite/map draw channels into framebuffer writes, drops transparent pixels, sweeps the framebuffer for VGA scan-out with read-latency alignment, and paces frames with a programmable tick. It sits between the game control FSM, the drawing sources (map, link, enemies, HUD) and the single-port frame_buffer RAM.

## Interface
- NUM_CH, 4, number of draw channels; index 0 has highest priority
- SCREEN_W, 256, pixels per line
- SCREEN_H, 176, lines per frame
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOUR_W, 6, pixel colour width
- ADDR_W, 16, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H
- TRANSP_EN, 1, 1 = enable transparency-key drop
- TRANSP_KEY, 6'b110011, colour that is never written when TRANSP_EN=1
- RD_LAT, 1, framebuffer read latency in cycles (1..3)
- FRAME_TICKS, 1666666, clock cycles per frame tick

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ch_en  in  NUM_CH  per-channel draw enable (level, from control)
- ch_done  in  NUM_CH  per-channel source-finished flag
- ch_x  in  NUM_CH*X_W  flattened source x, channel i at [i*X_W +: X_W]
- ch_y  in  NUM_CH*Y_W  flattened source y
- ch_colour  in  NUM_CH*COLOUR_W  flattened source colour
- ch_write  in  NUM_CH  per-channel pixel-valid
- ch_grant  out  NUM_CH  one-hot grant, registered
- scan_start  in  1  request one full-frame scan-out
- fb_addr  out  ADDR_W  framebuffer address, y*SCREEN_W+x
- fb_colour  out  COLOUR_W  write data
- fb_wren  out  1  write enable
- fb_q  in  COLOUR_W  framebuffer read data
- vga_x  out  X_W  scan-out pixel x, aligned with vga_colour
- vga_y  out  Y_W  scan-out pixel y
- vga_colour  out  COLOUR_W  scan-out pixel colour
- vga_plot  out  1  vga_x/y/colour valid
- scan_done  out  1  one-cycle pulse, last scan pixel delivered
- frame_tick  out  1  one-cycle pulse every FRAME_TICKS cycles

## Operation
- States: IDLE, DRAW, SCAN, DRAIN.
- IDLE: if any ch_en[i] & !ch_done[i], grant lowest such i -> DRAW; else if scan_start -> SCAN; draw wins over simultaneous scan_start, scan_start held pending (sticky) until taken.
- DRAW: each cycle registers granted channel's x/y/colour; fb_wren = ch_write[g] & !(TRANSP_EN & colour==TRANSP_KEY). On ch_done[g] or ch_en[g] low: fb_wren 0 that cycle, grant cleared, -> IDLE (re-arbitrate; no preemption mid-channel).
- SCAN: counter x 0..SCREEN_W-1, y 0..SCREEN_H-1 raster order, one address/cycle, fb_wren 0. After last address -> DRAIN.
- DRAIN: waits RD_LAT cycles, then scan_done pulse, -> IDLE.
- Read path: x/y and valid delayed RD_LAT stages; vga_colour = fb_q when vga_plot.
- frame_tick counter free-runs in all states, wraps at FRAME_TICKS-1.
- Coordinates outside SCREEN_W/SCREEN_H in DRAW: write suppressed.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pending scan cleared.
- Grant: 1 cycle from ch_en rising to ch_grant; source pixel at cycle n appears on fb_* at n+1.
- Scan: first fb_addr 1 cycle after scan_start accepted; first vga_plot RD_LAT cycles later; SCREEN_W*SCREEN_H consecutive vga_plot cycles; scan_done 1 cycle after last vga_plot.
- Address arithmetic at ADDR_W bits, no overflow by parameter constraint.
- Reset mid-operation: immediate return to IDLE, fb_wren and vga_plot deasserted asynchronously.

## Structure
- Shared package game_pkg: state encoding, default SCREEN_W/H, COLOUR_W, TRANSP_KEY.
- Sub-module fb_addr_translate (parametrised y*SCREEN_W+x), instanced for write and scan paths share one instance via mux.
- Read-alignment delay line is a generate loop of RD_LAT registers.

## Test plan
- ch_en=4'b0110, ch2 and ch1 active -> ch_grant=4'b0010 first; after ch_done[1], ch_grant=4'b0100.
- Granted ch0 pixel (10,20) colour 6'h15 write=1 -> next cycle fb_addr=5130, fb_colour=6'h15, fb_wren=1.
- Same pixel with colour TRANSP_KEY, TRANSP_EN=1 -> fb_wren=0; TRANSP_EN=0 -> fb_wren=1.
- scan_start with RD_LAT=2, SCREEN 4x2 -> 8 vga_plot cycles, vga_x/y (0,0)..(3,1) paired with fb_q of matching address, scan_done one cycle after.
- scan_start asserted one cycle while ch3 drawing -> scan runs after ch3 done, not lost.
- reset low mid-SCAN -> all outputs 0 within the same cycle; FRAME_TICKS=5 after release -> frame_tick at cycle 5, 10, 15.
